branch_predictor_sa: RTL and testbench
======================================

Name: branch_predictor_sa

Overview:
- Parametrised successor to the core's direct-mapped BTB/BHT front-end predictor.
- Adds a set-associative BTB (1 or 2 ways, LRU replacement) and a pattern history table (PHT) of 2-bit saturating counters, optionally gshare-indexed.
- Adds resolved-branch and mispredict statistics counters.
- Sits in the IF stage: predicts NPC combinationally from PC_IF, and is trained by the resolved branch in EX.

Parameters:
- BTB_SET_LEN, 3, log2 of BTB set count.
- BTB_WAYS, 2, associativity; legal values 1 or 2.
- PHT_LEN, 10, log2 of PHT entry count.
- GHR_LEN, 8, global history bits; must satisfy GHR_LEN <= PHT_LEN.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- PC_IF  in  32  fetch PC.
- NPC_PRED  out  32  predicted next PC.
- PRED_TAKEN  out  1  prediction is taken, for PC_IF.
- br_inst  in  1  EX holds a conditional branch (update valid).
- br  in  1  actual branch outcome in EX (1 = taken).
- PC_EX  in  32  address of the branch in EX.
- br_target  in  32  resolved target of the branch in EX.
- PRED_TAKEN_EX  in  1  prediction that was made for the branch in EX.
- mispred  out  1  combinational: br_inst & (br ^ PRED_TAKEN_EX).
- br_cnt  out  CNT_W  count of resolved branches.
- mispred_cnt  out  CNT_W  count of mispredicted branches.

Behaviour:
- Field split
  - set = PC[BTB_SET_LEN+1:2]
  - tag = PC[31:BTB_SET_LEN+2]
  - PC[1:0] ignored.
- BTB entry: valid, tag, target. One LRU bit per set when BTB_WAYS=2; the LRU bit names the way to evict next.
- Lookup (combinational, zero latency)
  - hit = any way with valid and a tag match on PC_IF.
  - PRED_TAKEN = hit & PHT[pidx(PC_IF)][1].
  - NPC_PRED = PRED_TAKEN ? hit_target : PC_IF+4, with 32-bit wrap.
  - Lookup never changes LRU.
- PHT index pidx(PC) = PC[PHT_LEN+1:2], XOR-combined per the Optional Feature.
- Update occurs on the clk edge when br_inst=1 and rst=0. All of the following use the pre-edge GHR:
  - PHT[pidx(PC_EX)]: if br, increment, saturating at 2'b11; otherwise decrement, saturating at 2'b00.
  - br=1, BTB hit on PC_EX: overwrite that way's target; set LRU to the other way.
  - br=1, BTB miss: allocate to the first invalid way (way 0 first), else to the LRU way. Write valid=1, tag, and target; set LRU to the other way.
  - br=0: BTB unchanged, including LRU.
  - GHR <= {GHR[GHR_LEN-2:0], br}.
  - br_cnt increments by 1; mispred_cnt increments by 1 when mispred. Both saturate at all-ones and do not wrap.
- br_inst=0: no state changes; br, PC_EX, br_target and PRED_TAKEN_EX are ignored.
- Same cycle, same set or PHT entry for lookup and update: the lookup returns the pre-update contents. The new contents are visible from the next cycle.
- BTB_WAYS=1: direct-mapped; there is no LRU state and allocation always overwrites.
- Reset (synchronous; dominates a coincident update)
  - All valid bits 0; LRU 0.
  - All PHT counters 2'b01 (weakly not-taken).
  - GHR 0; br_cnt and mispred_cnt 0.
  - Outputs after reset: PRED_TAKEN=0, NPC_PRED=PC_IF+4.
  - Reset mid-run discards all training.
- Each PHT counter writes at most once per cycle, and each BTB set at most once per cycle.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- Defined: pidx = PC[PHT_LEN+1:2] ^ {{(PHT_LEN-GHR_LEN){1'b0}}, GHR}. The GHR is maintained as specified.
- Undefined: pidx = PC[PHT_LEN+1:2] (bimodal). The GHR register is not instantiated.
- BTB and statistics behaviour are identical in both builds.

Test Plan:
(Macro undefined unless stated.)
1. Reset, then PC_IF=0x100 -> PRED_TAKEN=0, NPC_PRED=0x104, br_cnt=0, mispred_cnt=0.
2. Two updates: PC_EX=0x100, br=1, br_target=0x40, PRED_TAKEN_EX=0 -> counter goes 01->10->11; then PC_IF=0x100 gives PRED_TAKEN=1, NPC_PRED=0x40; br_cnt=2, mispred_cnt=2.
3. Train 0x100 to 2'b11, then one not-taken update -> counter 10, still predicts taken to 0x40; a second not-taken update -> counter 01, NPC_PRED=0x104.
4. With BTB_SET_LEN=3, take branches at 0x100, 0x120 and 0x140 (same set 0) in order -> 0x140 evicts 0x100 (the LRU way); 0x120 still hits and 0x100 misses (NPC_PRED=0x104).
5. In the same cycle: lookup PC_IF=0x100 and first taken update of 0x100 -> lookup shows a miss; the next cycle shows a hit, with PHT=10 so PRED_TAKEN=1. Asserting rst together with an update -> the update is discarded and all state is reset.
6. BRANCH_PREDICTOR_GSHARE_EN defined: three taken updates at 0x200 -> GHR=0b111. The updates use PHT indices 0x080, 0x081 and 0x083.

Source files
------------

// File: rtl/branch_predictor_sa.sv
// branch_predictor_sa: IF-stage next-PC predictor.
// Set-associative BTB (1 or 2 ways, LRU replacement) plus a PHT of 2-bit
// saturating counters, trained by the resolved conditional branch in EX.
// Build option: define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history
// register into the PHT index (gshare); otherwise the PHT is bimodal and no
// history register exists.
module branch_predictor_sa #(
   parameter int BTB_SET_LEN = 3,
   parameter int BTB_WAYS    = 2,
   parameter int PHT_LEN     = 10,
   parameter int GHR_LEN     = 8,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      PC_IF,
   output logic [31:0]      NPC_PRED,
   output logic             PRED_TAKEN,
   input  logic             br_inst,
   input  logic             br,
   input  logic [31:0]      PC_EX,
   input  logic [31:0]      br_target,
   input  logic             PRED_TAKEN_EX,
   output logic             mispred,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int SETS  = 1 << BTB_SET_LEN;
   localparam int TAG_W = 30 - BTB_SET_LEN;
   localparam int PHT_N = 1 << PHT_LEN;

   // BTB storage, indexed [way][set]
   logic             valid_r  [BTB_WAYS][SETS];
   logic [TAG_W-1:0] tag_r    [BTB_WAYS][SETS];
   logic [31:0]      target_r [BTB_WAYS][SETS];

   // Pattern history table of 2-bit counters
   logic [1:0]       pht_r [PHT_N];

   // History term folded into the PHT index (zero in the bimodal build)
   logic [PHT_LEN-1:0] hist_s;

   // Lookup-side decode
   logic [BTB_SET_LEN-1:0] set_if_s;
   logic [TAG_W-1:0]       tag_if_s;
   logic [PHT_LEN-1:0]     pidx_if_s;
   logic [BTB_WAYS-1:0]    hit_vec_if_s;
   logic                   hit_if_s;
   logic [31:0]            hit_tgt_s;
   logic                   pred_taken_s;

   // Update-side decode
   logic [BTB_SET_LEN-1:0] set_ex_s;
   logic [TAG_W-1:0]       tag_ex_s;
   logic [PHT_LEN-1:0]     pidx_ex_s;
   logic [BTB_WAYS-1:0]    hit_vec_ex_s;
   logic                   hit_ex_s;
   logic                   hit_way_ex_s;
   logic                   lru_ex_s;
   logic                   alloc_way_s;
   logic [1:0]             pht_cur_s;
   logic [1:0]             pht_next_s;
   logic                   btb_wr_s;
   logic                   pc_ex_unused_s;

   function automatic logic [BTB_SET_LEN-1:0] set_of(input logic [31:0] pc);
      return pc[BTB_SET_LEN+1:2];
   endfunction

   function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
      return pc[31:BTB_SET_LEN+2];
   endfunction

   function automatic logic [PHT_LEN-1:0] pidx_of(input logic [31:0]        pc,
                                                  input logic [PHT_LEN-1:0] hist);
      return pc[PHT_LEN+1:2] ^ hist;
   endfunction

`ifdef BRANCH_PREDICTOR_GSHARE_EN
   logic [GHR_LEN-1:0] ghr_r;

   // Global history: shift in each resolved outcome
   always_ff @(posedge clk) begin
      if (rst) begin
         ghr_r <= {GHR_LEN{1'b0}};
      end else if (br_inst) begin
         ghr_r <= {ghr_r[GHR_LEN-2:0], br};
      end else begin
         ghr_r <= ghr_r;
      end
   end

   assign hist_s = PHT_LEN'(ghr_r);
`else
   assign hist_s = {PHT_LEN{1'b0}};
`endif

   assign set_if_s  = set_of(PC_IF);
   assign tag_if_s  = tag_of(PC_IF);
   assign pidx_if_s = pidx_of(PC_IF, hist_s);
   assign set_ex_s  = set_of(PC_EX);
   assign tag_ex_s  = tag_of(PC_EX);
   assign pidx_ex_s = pidx_of(PC_EX, hist_s);

   // Only the word address of the EX branch matters
   assign pc_ex_unused_s = ^PC_EX[1:0];

   // Per-way tag compare for both the fetch lookup and the EX update
   always_comb begin
      hit_vec_if_s = {BTB_WAYS{1'b0}};
      hit_vec_ex_s = {BTB_WAYS{1'b0}};
      for (int w = 0; w < BTB_WAYS; w++) begin
         hit_vec_if_s[w] = valid_r[w][set_if_s] && (tag_r[w][set_if_s] == tag_if_s);
         hit_vec_ex_s[w] = valid_r[w][set_ex_s] && (tag_r[w][set_ex_s] == tag_ex_s);
      end
   end

   assign hit_if_s     = |hit_vec_if_s;
   assign hit_ex_s     = |hit_vec_ex_s;
   assign hit_way_ex_s = hit_vec_ex_s[0] ? 1'b0 : 1'(BTB_WAYS - 1);

   // Select the target of the hitting way (tags are unique within a set)
   always_comb begin
      hit_tgt_s = 32'h0000_0000;
      if (hit_vec_if_s[0]) begin
         hit_tgt_s = target_r[0][set_if_s];
      end else begin
         hit_tgt_s = target_r[BTB_WAYS-1][set_if_s];
      end
   end

   assign pred_taken_s = hit_if_s & pht_r[pidx_if_s][1];
   assign PRED_TAKEN   = pred_taken_s;
   assign NPC_PRED     = pred_taken_s ? hit_tgt_s : (PC_IF + 32'd4);
   assign mispred      = br_inst & (br ^ PRED_TAKEN_EX);

   generate
      if (BTB_WAYS == 2) begin : g_lru
         logic [SETS-1:0] lru_r;

         // LRU bit names the way to evict next; point it away from the written way
         always_ff @(posedge clk) begin
            if (rst) begin
               lru_r <= {SETS{1'b0}};
            end else if (btb_wr_s) begin
               lru_r[set_ex_s] <= ~alloc_way_s;
            end else begin
               lru_r <= lru_r;
            end
         end

         assign lru_ex_s = lru_r[set_ex_s];
      end else begin : g_no_lru
         assign lru_ex_s = 1'b0;
      end
   endgenerate

   // Victim choice: hitting way, else first invalid way, else LRU way
   always_comb begin
      alloc_way_s = 1'b0;
      if (hit_ex_s) begin
         alloc_way_s = hit_way_ex_s;
      end else if (!valid_r[0][set_ex_s]) begin
         alloc_way_s = 1'b0;
      end else if (!valid_r[BTB_WAYS-1][set_ex_s]) begin
         alloc_way_s = 1'(BTB_WAYS - 1);
      end else begin
         alloc_way_s = lru_ex_s;
      end
   end

   assign btb_wr_s = br_inst & br;

   // BTB write: only taken branches allocate or refresh an entry
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int w = 0; w < BTB_WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               valid_r[w][s] <= 1'b0;
            end
         end
      end else if (btb_wr_s) begin
         valid_r[alloc_way_s][set_ex_s]  <= 1'b1;
         tag_r[alloc_way_s][set_ex_s]    <= tag_ex_s;
         target_r[alloc_way_s][set_ex_s] <= br_target;
      end else begin
         valid_r <= valid_r;
      end
   end

   // Saturating counter step toward the resolved outcome
   always_comb begin
      pht_cur_s  = pht_r[pidx_ex_s];
      pht_next_s = pht_cur_s;
      if (br) begin
         pht_next_s = (pht_cur_s == 2'b11) ? pht_cur_s : (pht_cur_s + 2'b01);
      end else begin
         pht_next_s = (pht_cur_s == 2'b00) ? pht_cur_s : (pht_cur_s - 2'b01);
      end
   end

   // PHT write on every resolved branch; reset to weakly not-taken
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PHT_N; i++) begin
            pht_r[i] <= 2'b01;
         end
      end else if (br_inst) begin
         pht_r[pidx_ex_s] <= pht_next_s;
      end else begin
         pht_r <= pht_r;
      end
   end

   // Statistics counters, saturating at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt      <= {CNT_W{1'b0}};
         mispred_cnt <= {CNT_W{1'b0}};
      end else if (br_inst) begin
         br_cnt      <= (&br_cnt) ? br_cnt : (br_cnt + CNT_W'(1));
         mispred_cnt <= (mispred && !(&mispred_cnt)) ? (mispred_cnt + CNT_W'(1))
                                                     : mispred_cnt;
      end else begin
         br_cnt      <= br_cnt;
         mispred_cnt <= mispred_cnt;
      end
   end

endmodule

// File: tb/tb_branch_predictor_sa.sv
// Self-checking bench for branch_predictor_sa (default parameters).
// Expected values are hand-derived constants queued as stimulus is driven
// and compared against the DUT outputs on the falling clock edge.
module tb_branch_predictor_sa;

   logic        clk;
   logic        rst;
   logic [31:0] PC_IF;
   logic [31:0] NPC_PRED;
   logic        PRED_TAKEN;
   logic        br_inst;
   logic        br;
   logic [31:0] PC_EX;
   logic [31:0] br_target;
   logic        PRED_TAKEN_EX;
   logic        mispred;
   logic [31:0] br_cnt;
   logic [31:0] mispred_cnt;

   typedef struct {
      string       tag;
      int          sel;   // 0 PRED_TAKEN, 1 NPC_PRED, 2 br_cnt, 3 mispred_cnt, 4 mispred
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec_s = 0;
   int   n_err_s = 0;

   branch_predictor_sa dut (
      .clk          (clk),
      .rst          (rst),
      .PC_IF        (PC_IF),
      .NPC_PRED     (NPC_PRED),
      .PRED_TAKEN   (PRED_TAKEN),
      .br_inst      (br_inst),
      .br           (br),
      .PC_EX        (PC_EX),
      .br_target    (br_target),
      .PRED_TAKEN_EX(PRED_TAKEN_EX),
      .mispred      (mispred),
      .br_cnt       (br_cnt),
      .mispred_cnt  (mispred_cnt)
   );

   // Free-running clock, 10 ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec_s++;
      if (obs !== exp) begin
         n_err_s++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         0:       return {31'd0, PRED_TAKEN};
         1:       return NPC_PRED;
         2:       return br_cnt;
         3:       return mispred_cnt;
         4:       return {31'd0, mispred};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   // Pop and compare everything queued, at the falling edge of this cycle
   task automatic drain();
      exp_t e;
      @(negedge clk);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, observe(e.sel), e.exp);
      end
   endtask

   // All tasks start and end 1 ns after a rising edge
   task automatic next_cycle();
      drain();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic lookup(input string tag, input logic [31:0] pc,
                         input logic taken, input logic [31:0] npc);
      PC_IF = pc;
      push({tag, "_taken"}, 0, {31'd0, taken});
      push({tag, "_npc"}, 1, npc);
      next_cycle();
   endtask

   task automatic counts(input string tag, input logic [31:0] nb, input logic [31:0] nm);
      push({tag, "_br_cnt"}, 2, nb);
      push({tag, "_mis_cnt"}, 3, nm);
      next_cycle();
   endtask

   task automatic do_update(input logic [31:0] pc, input logic taken,
                            input logic [31:0] tgt, input logic pte);
      br_inst       = 1'b1;
      br            = taken;
      PC_EX         = pc;
      br_target     = tgt;
      PRED_TAKEN_EX = pte;
      push("mispred", 4, {31'd0, taken ^ pte});
      next_cycle();
      br_inst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; PC_IF = 32'h0; br_inst = 1'b0; br = 1'b0;
      PC_EX = 32'h0; br_target = 32'h0; PRED_TAKEN_EX = 1'b0;
      do_reset();

      // 1: reset state
      lookup("rst", 32'h100, 1'b0, 32'h104);
      counts("rst", 32'd0, 32'd0);
      lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

      // 2: two taken updates, both mispredicted
      do_update(32'h100, 1'b1, 32'h40, 1'b0);
      lookup("one_upd", 32'h100, 1'b1, 32'h40);
      do_update(32'h100, 1'b1, 32'h40, 1'b0);
      lookup("two_upd", 32'h100, 1'b1, 32'h40);
      counts("two_upd", 32'd2, 32'd2);

      // Idle cycle: br_inst=0 ignores the other EX inputs
      br_inst = 1'b0; br = 1'b1; PC_EX = 32'h100; br_target = 32'h999; PRED_TAKEN_EX = 1'b0;
      push("idle_mispred", 4, 32'd0);
      next_cycle();
      counts("idle", 32'd2, 32'd2);
      lookup("idle", 32'h100, 1'b1, 32'h40);

      // 3: hysteresis of the 2-bit counter
      do_update(32'h100, 1'b1, 32'h40, 1'b1);   // 11
      do_update(32'h100, 1'b0, 32'h0, 1'b1);    // 10
      lookup("hyst10", 32'h100, 1'b1, 32'h40);
      do_update(32'h100, 1'b0, 32'h0, 1'b1);    // 01
      lookup("hyst01", 32'h100, 1'b0, 32'h104);
      counts("hyst", 32'd5, 32'd4);

      // 4: LRU replacement within set 0
      do_reset();
      do_update(32'h100, 1'b1, 32'h1000, 1'b0);
      do_update(32'h120, 1'b1, 32'h2000, 1'b0);
      do_update(32'h140, 1'b1, 32'h3000, 1'b0);
      lookup("lru_140", 32'h140, 1'b1, 32'h3000);
      lookup("lru_120", 32'h120, 1'b1, 32'h2000);
      lookup("lru_100", 32'h100, 1'b0, 32'h104);
      do_update(32'h100, 1'b1, 32'h1004, 1'b0);  // evicts 0x120 now
      lookup("lru2_120", 32'h120, 1'b0, 32'h124);
      lookup("lru2_100", 32'h100, 1'b1, 32'h1004);
      do_update(32'h140, 1'b1, 32'h3300, 1'b1);  // hit: retarget
      lookup("retgt_140", 32'h140, 1'b1, 32'h3300);
      lookup("retgt_100", 32'h100, 1'b1, 32'h1004);
      counts("lru", 32'd5, 32'd4);

      // 5: same-cycle lookup sees pre-update state
      do_reset();
      PC_IF = 32'h100;
      push("same_taken", 0, 32'd0);
      push("same_npc", 1, 32'h104);
      do_update(32'h100, 1'b1, 32'h40, 1'b0);
      lookup("next_cyc", 32'h100, 1'b1, 32'h40);

      // Reset dominates a coincident update
      rst = 1'b1; br_inst = 1'b1; br = 1'b1; PC_EX = 32'h100;
      br_target = 32'h80; PRED_TAKEN_EX = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0; br_inst = 1'b0;
      lookup("rst_upd", 32'h100, 1'b0, 32'h104);
      counts("rst_upd", 32'd0, 32'd0);

      // 6: three taken updates at 0x200, then predict
      do_update(32'h200, 1'b1, 32'h500, 1'b0);
      do_update(32'h200, 1'b1, 32'h500, 1'b0);
      do_update(32'h200, 1'b1, 32'h500, 1'b0);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      // Trained indices 0x080/0x081/0x083; lookup index 0x087 is untouched
      lookup("hist", 32'h200, 1'b0, 32'h204);
`else
      lookup("hist", 32'h200, 1'b1, 32'h500);
`endif
      counts("hist", 32'd3, 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec_s, n_err_s);
      $finish;
   end

endmodule
